// File: rtl/led_status_pkg.sv
// Shared types and sizing helpers for the front-panel status-LED scheduler.
package led_status_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ON,
        OFF,
        GAP
    } led_state_t;

    localparam int ID_W = 3;
    localparam int BL_W = 4;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Free-running prescaler: one-cycle tick every TICK_DIV clocks, independent of the FSM.
module led_tick_gen
    import led_status_pkg::*;
#(
    parameter int TICK_DIV = 10000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = cnt_width(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           cnt <= '0;
        else if (cnt == LAST) cnt <= '0;
        else                  cnt <= cnt + CW'(1);
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/led_status_sched.sv
// Shares one status LED among NREQ requesters with identity-encoding blink bursts.
// Optional idle heartbeat: define LED_STATUS_SCHED_HEARTBEAT_EN.
module led_status_sched
    import led_status_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int TICK_DIV  = 10000,
    parameter int ON_TICKS  = 200,
    parameter int OFF_TICKS = 200,
    parameter int GAP_TICKS = 1000,
    parameter int HB_TICKS  = 500
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  ack,
    output logic             led,
    output logic             busy,
    output logic [ID_W-1:0]  active_id
);

    localparam int PH_W = cnt_width(max4(ON_TICKS, OFF_TICKS, GAP_TICKS, HB_TICKS));
    localparam logic [PH_W-1:0] ON_LAST  = PH_W'(ON_TICKS - 1);
    localparam logic [PH_W-1:0] OFF_LAST = PH_W'(OFF_TICKS - 1);
    localparam logic [PH_W-1:0] GAP_LAST = PH_W'(GAP_TICKS - 1);

    led_state_t       state;
    logic [PH_W-1:0]  ph;
    logic [BL_W-1:0]  blinks_left;
    logic [ID_W-1:0]  grant_id;
    logic             tick;

`ifdef LED_STATUS_SCHED_HEARTBEAT_EN
    localparam logic [PH_W-1:0] HB_LAST = PH_W'(HB_TICKS - 1);
    logic [PH_W-1:0]  hb_cnt;
`endif

    led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // Fixed priority: scanning downward lets the lowest set index win.
    // NOTE: the default before the loop keeps this combinational block latch-free.
    always_comb begin
        grant_id = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) grant_id = ID_W'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ph          <= '0;
            blinks_left <= '0;
            led         <= 1'b0;
            busy        <= 1'b0;
            ack         <= '0;
            active_id   <= '0;
`ifdef LED_STATUS_SCHED_HEARTBEAT_EN
            hb_cnt      <= '0;
`endif
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (tick) begin
                        if (|req) begin
                            active_id   <= grant_id;
                            blinks_left <= BL_W'(grant_id) + BL_W'(1);
                            ph          <= '0;
                            led         <= 1'b1;
                            busy        <= 1'b1;
                            state       <= ON;
`ifdef LED_STATUS_SCHED_HEARTBEAT_EN
                            hb_cnt      <= '0;
                        end else if (hb_cnt == HB_LAST) begin
                            hb_cnt <= '0;
                            led    <= ~led;
                        end else begin
                            hb_cnt <= hb_cnt + PH_W'(1);
`endif
                        end
                    end
                end
                ON: begin
                    if (tick) begin
                        if (ph == ON_LAST) begin
                            ph          <= '0;
                            blinks_left <= blinks_left - BL_W'(1);
                            led         <= 1'b0;
                            state       <= (blinks_left == BL_W'(1)) ? GAP : OFF;
                        end else begin
                            ph <= ph + PH_W'(1);
                        end
                    end
                end
                OFF: begin
                    if (tick) begin
                        if (ph == OFF_LAST) begin
                            ph    <= '0;
                            led   <= 1'b1;
                            state <= ON;
                        end else begin
                            ph <= ph + PH_W'(1);
                        end
                    end
                end
                GAP: begin
                    if (tick) begin
                        if (ph == GAP_LAST) begin
                            ph    <= '0;
                            busy  <= 1'b0;
                            state <= IDLE;
                            for (int i = 0; i < NREQ; i++) begin
                                ack[i] <= (active_id == ID_W'(i));
                            end
                        end else begin
                            ph <= ph + PH_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_status_sched.sv
// Scoreboard bench for led_status_sched: burst events are queued on stimulus and matched by a monitor.
`timescale 1ns/1ps
module tb_led_status_sched;
    import led_status_pkg::*;

    localparam int NREQ      = 4;
    localparam int TICK_DIV  = 4;
    localparam int ON_TICKS  = 2;
    localparam int OFF_TICKS = 2;
    localparam int GAP_TICKS = 3;
    localparam int HB_TICKS  = 5;
    localparam int ON_CLK    = ON_TICKS * TICK_DIV;
    localparam int OFF_CLK   = OFF_TICKS * TICK_DIV;

    typedef enum int {EV_NONE, EV_GRANT, EV_ON, EV_OFF, EV_ACK} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       val;
    } ev_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NREQ-1:0] req = '0;
    logic [NREQ-1:0] ack;
    logic            led;
    logic            busy;
    logic [ID_W-1:0] active_id;

    ev_t sb_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc = 0;
    int  ev_seq = 0;
    int  ack_count = 0;
    int  hb_toggles = 0;
    int  idle_led_hi = 0;
    int  n_wait;
    int  ack_before;

    led_status_sched #(
        .NREQ      (NREQ),
        .TICK_DIV  (TICK_DIV),
        .ON_TICKS  (ON_TICKS),
        .OFF_TICKS (OFF_TICKS),
        .GAP_TICKS (GAP_TICKS),
        .HB_TICKS  (HB_TICKS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .ack       (ack),
        .led       (led),
        .busy      (busy),
        .active_id (active_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic sb_match(input ev_kind_t k, input int v);
        ev_t e;
        ev_seq++;
        if (sb_q.size() == 0) begin
            check($sformatf("ev%0d_unexpected", ev_seq), k, EV_NONE);
        end else begin
            e = sb_q.pop_front();
            check($sformatf("ev%0d_kind", ev_seq), k, e.kind);
            check($sformatf("ev%0d_val", ev_seq), v, e.val);
        end
    endtask

    // Expected event stream for one full burst of requester k.
    function automatic void push_burst(input int k);
        sb_q.push_back('{kind: EV_GRANT, val: k});
        for (int b = 0; b <= k; b++) begin
            sb_q.push_back('{kind: EV_ON, val: ON_CLK});
            if (b < k) sb_q.push_back('{kind: EV_OFF, val: OFF_CLK});
        end
        sb_q.push_back('{kind: EV_ACK,
                         val: (1 << k) * 1000 + ((k + 1) * ON_TICKS + k * OFF_TICKS + GAP_TICKS) * TICK_DIV});
    endfunction

    task automatic wait_busy(input logic lvl, input int budget, input string tag);
        int n;
        n = 0;
        while (busy !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, busy, lvl);
    endtask

    task automatic monitor_loop();
        logic prev_led;
        logic prev_busy;
        int   grant_cyc;
        int   edge_cyc;
        int   hb_last;
        prev_led  = 1'b0;
        prev_busy = 1'b0;
        grant_cyc = 0;
        edge_cyc  = 0;
        hb_last   = -1;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                prev_led  = 1'b0;
                prev_busy = 1'b0;
                hb_last   = -1;
            end else begin
                if (busy && !prev_busy) begin
                    sb_match(EV_GRANT, int'(active_id));
                    grant_cyc = cyc;
                    edge_cyc  = cyc;
                end else if (busy && led !== prev_led) begin
                    sb_match(led ? EV_OFF : EV_ON, cyc - edge_cyc);
                    edge_cyc = cyc;
                end
                if (ack !== '0) begin
                    ack_count++;
                    sb_match(EV_ACK, int'(ack) * 1000 + (cyc - grant_cyc));
                end
                if (busy) begin
                    hb_last = -1;
                end else begin
                    if (led === 1'b1) idle_led_hi++;
                    if (!prev_busy && led !== prev_led) begin
                        hb_toggles++;
                        if (hb_last >= 0) check("hb_half_period", cyc - hb_last, HB_TICKS * TICK_DIV);
                        hb_last = cyc;
                    end
                end
                prev_led  = led;
                prev_busy = busy;
            end
        end
    endtask

    initial begin
        fork
            monitor_loop();
        join_none

        repeat (3) @(negedge clk);
        check("rst_led", led, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ack", ack, '0);
        check("rst_active_id", active_id, '0);
        rst_n = 1'b1;

        // Idle window: heartbeat or dark LED depending on build.
        repeat (120) @(negedge clk);
`ifdef LED_STATUS_SCHED_HEARTBEAT_EN
        check("hb_toggled", hb_toggles >= 5, 1);
`else
        check("idle_led_low", idle_led_hi, 0);
`endif

        // Single request, id 2: three blinks then ack after 52 clk.
        push_burst(2);
        req = 4'b0100;
        wait_busy(1'b1, 40, "single_grant");
        req = '0;
        wait_busy(1'b0, 200, "single_done");
        check("single_id", active_id, 2);
        repeat (7) @(negedge clk);

        // Request dropped right after the grant still completes its burst.
        push_burst(0);
        req = 4'b0001;
        wait_busy(1'b1, 40, "drop_grant");
        req = '0;
        wait_busy(1'b0, 200, "drop_done");
        repeat (5) @(negedge clk);

        // Priority: id 1 wins twice while held, then id 3 runs.
        push_burst(1);
        push_burst(1);
        req = 4'b1010;
        wait_busy(1'b1, 40, "prio_grant");
        wait_busy(1'b0, 200, "prio_done1");
        wait_busy(1'b1, 40, "prio_regrant");
        req = 4'b1000;
        push_burst(3);
        wait_busy(1'b0, 200, "prio_done2");
        wait_busy(1'b1, 40, "prio_low_grant");
        req = '0;
        wait_busy(1'b0, 300, "prio_done3");
        check("prio_id", active_id, 3);
        repeat (6) @(negedge clk);

        // Reset during the second ON phase of id 2.
        sb_q.push_back('{kind: EV_GRANT, val: 2});
        sb_q.push_back('{kind: EV_ON, val: ON_CLK});
        sb_q.push_back('{kind: EV_OFF, val: OFF_CLK});
        req = 4'b0100;
        wait_busy(1'b1, 40, "rst_grant");
        req = '0;
        repeat (20) @(negedge clk);
        check("rst_pre_led", led, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_led", led, 1'b0);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_ack", ack, '0);
        ack_before = ack_count;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (80) @(negedge clk);
        check("rst_no_ack", ack_count - ack_before, 0);
        check("rst_sb_drained", sb_q.size(), 0);

        // Tick counter restarts from 0: grant lands on the 4th clk after release.
        @(negedge clk);
        #1 rst_n = 1'b0;
        req = 4'b0001;
        push_burst(0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n_wait = 0;
        while (busy !== 1'b1 && n_wait < 20) begin
            @(negedge clk);
            n_wait++;
        end
        check("tick_restart", n_wait, 4);
        req = '0;
        wait_busy(1'b0, 100, "tick_done");
        repeat (10) @(negedge clk);
        check("sb_final_empty", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
